adc_frame_rx: RTL and testbench



---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_chan_seq.sv | 38 +++
 rtl/adc_frame_rx.sv | 158 +++++++++++++++
 tb/tb_adc_frame_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and default geometry for the ADC serial receive engine.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } adc_rx_state_t;

  localparam int ADC_DATA_W    = 12;
  localparam int ADC_FRAME_LEN = 16;
  localparam int ADC_ADDR_W    = 3;

endpackage

// File: rtl/adc_chan_seq.sv
// Channel address sequencer: holds the current ADC address and the next one to drive.
// ADC_CH_SEQ_EN selects round-robin scanning; otherwise the address is pinned to FIXED_CH.
module adc_chan_seq #(
  parameter int ADDR_W   = 3,
  parameter int N_CH     = 8,
  parameter int FIXED_CH = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_adc_o,
  output logic [ADDR_W-1:0] next_ch_o
);

`ifdef ADC_CH_SEQ_EN
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign next_ch_o  = (addr_q == ADDR_W'(N_CH - 1)) ? '0 : addr_q + 1'b1;
  assign addr_adc_o = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (advance_i) addr_d = next_ch_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= addr_d;
  end
`else
  logic seq_unused;

  assign addr_adc_o = ADDR_W'(FIXED_CH);
  assign next_ch_o  = ADDR_W'(FIXED_CH);
  assign seq_unused = clk_i ^ rst_i ^ advance_i;
`endif

endmodule

// File: rtl/adc_frame_rx.sv
// Serial ADC frame receiver: drives the channel address, captures DATA_W result bits
// and presents them on a valid/ready port. Channel scanning is enabled by ADC_CH_SEQ_EN.
module adc_frame_rx
  import adc_pkg::*;
#(
  parameter int DATA_W    = ADC_DATA_W,
  parameter int FRAME_LEN = ADC_FRAME_LEN,
  parameter int LEAD_BITS = 4,
  parameter int ADDR_W    = ADC_ADDR_W,
  parameter int ADDR_POS  = 2,
  parameter int N_CH      = 8,
  parameter int FIXED_CH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_adc,
  input  logic              dout_adc,
  output logic              din_adc,
  output logic [ADDR_W-1:0] addr_adc,
  output logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LEAD_C   = CNT_W'(LEAD_BITS);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(LEAD_BITS + DATA_W - 1);
  localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] AP_C     = CNT_W'(ADDR_POS);
  localparam logic [CNT_W-1:0] AP_END_C = CNT_W'(ADDR_POS + ADDR_W);

  adc_rx_state_t     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              err_q, err_d;

  logic              capture, load;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  addr_off;
  logic [ADDR_W-1:0] addr_sh;
  logic [ADDR_W-1:0] next_ch;

  adc_chan_seq #(
    .ADDR_W   (ADDR_W),
    .N_CH     (N_CH),
    .FIXED_CH (FIXED_CH)
  ) u_chan_seq (
    .clk_i      (clk),
    .rst_i      (rst),
    .advance_i  (load),
    .addr_adc_o (addr_adc),
    .next_ch_o  (next_ch)
  );

  // The IDLE->SHIFT edge is itself frame bit 0, so capture covers both states.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    err_d     = 1'b0;
    capture   = 1'b0;
    load      = 1'b0;
    shifted   = {shift_q, dout_adc};

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_adc) begin
          capture   = 1'b1;
          state_d   = SHIFT;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cs_adc) begin
          err_d     = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          capture   = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (cs_adc) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (bit_cnt_q < FRAME_C) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = DONE;
    endcase

    if (capture && bit_cnt_q >= LEAD_C && bit_cnt_q <= LAST_C) shift_d = shifted[DATA_W-2:0];
    if (capture && bit_cnt_q == LAST_C) begin
      load    = 1'b1;
      state_d = DONE;
    end

    // A load on the same edge as a transfer keeps valid set and is not an overrun.
    if (load) begin
      data_d    = shifted;
      ch_d      = addr_adc;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~sample_ready;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    addr_off = bit_cnt_q - AP_C;
    addr_sh  = next_ch << addr_off;
    din_adc  = 1'b0;
    if (state_q != DONE && bit_cnt_q >= AP_C && bit_cnt_q < AP_END_C) din_adc = addr_sh[ADDR_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DONE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_adc_frame_rx.sv
// Self-checking bench for adc_frame_rx: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_adc_frame_rx;

  localparam int DW  = 12;
  localparam int FL  = 16;
  localparam int LB  = 4;
  localparam int AW  = 3;
  localparam int AP  = 2;
  localparam int NCH = 8;
  localparam int FCH = 5;
`ifdef ADC_CH_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_adc = 1'b1;
  logic          dout_adc = 1'b0;
  logic          sample_ready = 1'b0;
  logic          din_adc;
  logic [AW-1:0] addr_adc;
  logic [DW-1:0] sample_data;
  logic [AW-1:0] sample_ch;
  logic          sample_valid;
  logic          overrun;
  logic          frame_err;

  always #5 clk = ~clk;

  adc_frame_rx #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .LEAD_BITS (LB),
    .ADDR_W    (AW),
    .ADDR_POS  (AP),
    .N_CH      (NCH),
    .FIXED_CH  (FCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cs_adc       (cs_adc),
    .dout_adc     (dout_adc),
    .din_adc      (din_adc),
    .addr_adc     (addr_adc),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is "armed" once cs has been seen high; pos counts its low edges.
  bit            m_armed = 1'b0;
  int unsigned   m_pos   = 0;
  logic [DW-1:0] m_acc   = '0;
  logic [DW-1:0] m_data  = '0;
  logic [AW-1:0] m_ch    = '0;
  logic [AW-1:0] m_addr  = '0;
  bit            m_valid = 1'b0;
  bit            m_ovr   = 1'b0;
  bit            m_err   = 1'b0;
  bit            chk_en  = 1'b0;

  function automatic logic [AW-1:0] next_of(input logic [AW-1:0] a);
    if (!SEQ) return AW'(FCH);
    return (int'(a) == NCH - 1) ? '0 : a + 1'b1;
  endfunction

  function automatic logic exp_din();
    logic [AW-1:0] n;
    n = next_of(m_addr);
    if (m_armed && m_pos >= AP && m_pos < AP + AW) return n[AW-1-(m_pos-AP)];
    return 1'b0;
  endfunction

  task automatic model_edge(input logic c, input logic d, input logic r, input logic rs);
    bit xfer, ld;
    if (rs) begin
      m_armed = 0; m_pos = 0; m_acc = '0; m_data = '0; m_ch = '0;
      m_addr = SEQ ? '0 : AW'(FCH); m_valid = 0; m_ovr = 0; m_err = 0;
      return;
    end
    xfer = m_valid && r;
    ld = 0; m_ovr = 0; m_err = 0;
    if (c) begin
      if (m_armed && m_pos > 0) m_err = 1;
      m_armed = 1; m_pos = 0;
    end else if (m_armed) begin
      if (m_pos >= LB && m_pos < LB + DW) m_acc = {m_acc[DW-2:0], d};
      if (m_pos == LB + DW - 1) begin ld = 1; m_armed = 0; end
      m_pos++;
    end
    if (ld) begin
      m_ovr = m_valid && !xfer;
      m_valid = 1; m_data = m_acc; m_ch = m_addr; m_addr = next_of(m_addr);
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  int vcnt = 0, ocnt = 0, ecnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("sample_valid", 32'(sample_valid), 32'(m_valid));
      check("sample_data",  32'(sample_data),  32'(m_data));
      check("sample_ch",    32'(sample_ch),    32'(m_ch));
      check("overrun",      32'(overrun),      32'(m_ovr));
      check("frame_err",    32'(frame_err),    32'(m_err));
      check("addr_adc",     32'(addr_adc),     32'(m_addr));
      check("din_adc",      32'(din_adc),      32'(exp_din()));
    end
    if (sample_valid === 1'b1) vcnt++;
    if (overrun === 1'b1) ocnt++;
    if (frame_err === 1'b1) ecnt++;
  end

  int   rdy_mode = 1;
  logic last_din;

  function automatic logic rdyv();
    if (rdy_mode == 0) return 1'b0;
    if (rdy_mode == 1) return 1'b1;
    return 1'($urandom % 2);
  endfunction

  task automatic step(input logic c, input logic d, input logic r, input logic rs);
    @(negedge clk);
    #1;
    cs_adc = c; dout_adc = d; sample_ready = r; rst = rs;
    last_din = din_adc;
    @(posedge clk);
    model_edge(c, d, r, rs);
  endtask

  task automatic send_frame(input logic [DW-1:0] dat, input int unsigned nlow, output logic [AW-1:0] din3);
    logic b;
    int unsigned gap;
    din3 = '0;
    for (int unsigned i = 0; i < nlow; i++) begin
      if (i >= LB && i < LB + DW) b = dat[LB+DW-1-i];
      else b = 1'($urandom % 2);
      step(1'b0, b, rdyv(), 1'b0);
      if (i >= AP && i < AP + AW) din3[AW-1-(i-AP)] = last_din;
    end
    gap = 1 + $urandom % 3;
    for (int unsigned g = 0; g < gap; g++) step(1'b1, 1'($urandom % 2), rdyv(), 1'b0);
  endtask

  initial begin
    logic [AW-1:0] d3;
    logic [AW-1:0] a0;
    int v0, o0, e0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("reset valid", 32'(sample_valid), 32'h0);
    check("reset data",  32'(sample_data),  32'h0);
    check("reset din",   32'(din_adc),      32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Single frame carrying 0xA5C with ready held high.
    rdy_mode = 1;
    v0 = vcnt;
    send_frame(12'hA5C, 16, d3);
    check("A5C data", 32'(sample_data), 32'hA5C);
    check("A5C ch", 32'(sample_ch), SEQ ? 32'h0 : 32'h5);
    check("A5C din bits", 32'(d3), SEQ ? 32'h1 : 32'h5);
    check("A5C valid cycles", 32'(vcnt - v0), 32'h1);

    // Eight more frames: addr_adc ends one step past a full wrap.
    for (int k = 0; k < 8; k++) send_frame(DW'($urandom), 16, d3);
    check("scan addr", 32'(addr_adc), SEQ ? 32'h1 : 32'h5);
    check("scan ch", 32'(sample_ch), SEQ ? 32'h0 : 32'h5);
    check("scan din bits", 32'(d3), SEQ ? 32'h1 : 32'h5);

    // Two unconsumed results.
    rdy_mode = 0;
    o0 = ocnt;
    send_frame(12'h123, 16, d3);
    send_frame(12'h456, 16, d3);
    check("overrun pulses", 32'(ocnt - o0), 32'h1);
    check("overrun data", 32'(sample_data), 32'h456);
    check("overrun valid", 32'(sample_valid), 32'h1);
    rdy_mode = 1;
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Abort with cs rising at bit 9, then a clean frame.
    a0 = addr_adc; v0 = vcnt; e0 = ecnt;
    send_frame(DW'($urandom), 9, d3);
    check("abort err pulses", 32'(ecnt - e0), 32'h1);
    check("abort no valid", 32'(vcnt - v0), 32'h0);
    check("abort addr", 32'(addr_adc), 32'(a0));
    send_frame(12'h3C7, 16, d3);
    check("post-abort data", 32'(sample_data), 32'h3C7);

    // Reset at bit 7 of a 20-edge low period.
    v0 = vcnt;
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom % 2), 1'b1, (i == 7) ? 1'b1 : 1'b0);
    check("reset-mid no valid", 32'(vcnt - v0), 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(12'h9E1, 16, d3);
    check("post-reset data", 32'(sample_data), 32'h9E1);
    check("post-reset ch", 32'(sample_ch), SEQ ? 32'h0 : 32'h5);

    // Random frames, random ready, occasional aborts and long cs-low tails.
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      if ($urandom % 4 == 0) send_frame(DW'($urandom), 1 + $urandom % 15, d3);
      else send_frame(DW'($urandom), 16 + $urandom % 3, d3);
    end

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
